systolic_mm_arbiter: RTL and testbench
======================================

SYSTOLIC_MM_ARBITER -- requirements
Module: systolic_mm_arbiter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4, as the result element width.
REQ-002 The block SHALL take parameter SIZE, default 2, as the matrix order N.
REQ-003 The block SHALL take parameter WIDTHx, default 8, as the operand element width.
REQ-004 The block SHALL take parameter TIMEOUT, default 64, as the maximum WAIT cycles before an error.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port nreset, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port req_i, input, 2 bits: job request per client, held until done.
REQ-008 The block SHALL have ports a0_i, b0_i, a1_i, b1_i, input, WIDTHx*SIZE bits each: the current operand beat of clients 0 and 1.
REQ-009 The block SHALL have port gnt_o, output, 2 bits: one-hot grant; the granted client advances one beat per cycle while its bit is high.
REQ-010 The block SHALL have port done_o, output, 2 bits: one-cycle completion pulse per client.
REQ-011 The block SHALL have port err_o, output, 1 bit: qualifies done_o as a timed-out job.
REQ-012 The block SHALL have port result_o, output, WIDTH*SIZE*SIZE bits: the captured product, element [r][c] at bits (r*SIZE+c)*WIDTH.
REQ-013 The block SHALL have ports mm_valid_o (output, 1 bit), mm_a_o and mm_b_o (output, WIDTHx*SIZE bits each): the drive to the multiplier array.
REQ-014 The block SHALL have ports mm_ready_i (input, 1 bit) and mm_result_i (input, WIDTH*SIZE*SIZE bits): the multiplier array's completion flag and product.

Function
REQ-015 The FSM SHALL have four states: IDLE, STREAM, WAIT, DONE.
REQ-016 In IDLE with any req_i bit high, the FSM SHALL select the owner, register it, and go to STREAM on the next edge.
REQ-017 STREAM SHALL last exactly SIZE cycles, counted by a beat counter running 0..SIZE-1.
REQ-018 During STREAM, the block SHALL hold gnt_o[owner]=1 and all other gnt_o bits at 0.
REQ-019 During STREAM, mm_a_o and mm_b_o SHALL present the owner's a/b inputs combinationally.
REQ-020 mm_valid_o SHALL be high only in the first STREAM cycle.
REQ-021 Outside STREAM, mm_a_o and mm_b_o SHALL be 0.
REQ-022 After beat SIZE-1, the FSM SHALL enter WAIT and clear the timeout counter.
REQ-023 In WAIT with mm_ready_i=1, the block SHALL register mm_result_i into result_o, clear err_o, and go to DONE.
REQ-024 In WAIT, when the timeout counter reaches TIMEOUT-1 with mm_ready_i low, the block SHALL set err_o=1, leave result_o unchanged, and go to DONE.
REQ-025 If mm_ready_i is high in the same cycle the timeout counter reaches TIMEOUT-1, the block SHALL treat it as success.
REQ-026 In DONE, done_o[owner] SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-027 err_o SHALL be valid only while done_o is nonzero; outside that cycle it is held at 0.
REQ-028 result_o SHALL hold its value until the next successful capture.
REQ-029 A client dropping req_i during STREAM or WAIT SHALL NOT abort the job; done_o still pulses.
REQ-030 Arbitration SHALL occur only in IDLE.
REQ-031 A request arriving during a job SHALL wait.
REQ-032 Back-to-back jobs SHALL have exactly one IDLE cycle between DONE and the next STREAM.
REQ-033 mm_ready_i outside WAIT SHALL be ignored.

Reset
REQ-034 With nreset low, the block SHALL set state=IDLE, owner=0, all counters=0, and gnt_o=0, done_o=0, err_o=0, result_o=0, mm_valid_o=0, mm_a_o=0, mm_b_o=0, asynchronously.
REQ-035 Reset asserted mid-job SHALL abandon the job with no done_o pulse.
REQ-036 After reset release, the block SHALL arbitrate afresh with the round-robin pointer at client 0.

Configuration
REQ-037 When SYSTOLIC_RR_EN is defined, the block SHALL arbitrate round-robin: with both requests high, it grants the client other than the last granted client; after reset, client 0 has priority.
REQ-038 When SYSTOLIC_RR_EN is undefined, the block SHALL use fixed priority with client 0 always winning, and no pointer register is synthesized.

Verification
REQ-039 Bench SHALL cover a single job: SIZE=2, req_i=01, A=[[1,2],[3,4]] beats, mock array returns ready after 5 cycles with product=19,22,43,50 (WIDTH=8) -> gnt_o=01 for 2 cycles, mm_valid_o 1 cycle, done_o=01 once, err_o=0, result_o matches.
REQ-040 Bench SHALL cover contention: req_i=11 held for two jobs -> without SYSTOLIC_RR_EN, both grants go to client 0; with SYSTOLIC_RR_EN, grants go client 0 then client 1.
REQ-041 Bench SHALL cover timeout: TIMEOUT=8, mm_ready_i never asserted -> done_o pulses 8 cycles after entering WAIT with err_o=1 and result_o unchanged.
REQ-042 Bench SHALL cover the boundary: mm_ready_i first asserted on WAIT cycle 7 with TIMEOUT=8 -> success, err_o=0.
REQ-043 Bench SHALL cover reset mid-job: nreset pulsed low during WAIT -> all outputs 0 immediately, no done_o, next req_i=10 granted to client 1 cleanly.
REQ-044 Bench SHALL cover a request drop: client drops req_i in the 2nd STREAM cycle -> job completes, done_o pulses for that client.

Source files
------------

// File: rtl/systolic_mm_arbiter.sv
// Two-client arbiter that streams a job's operand beats into a systolic multiplier and captures the product.
// Build option SYSTOLIC_RR_EN: round-robin arbitration; otherwise fixed priority to client 0.
module systolic_mm_arbiter #(
  parameter int WIDTH   = 4,
  parameter int SIZE    = 2,
  parameter int WIDTHx  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                          clock,
  input  logic                          nreset,
  input  logic [1:0]                    req_i,
  input  logic [WIDTHx*SIZE-1:0]        a0_i,
  input  logic [WIDTHx*SIZE-1:0]        b0_i,
  input  logic [WIDTHx*SIZE-1:0]        a1_i,
  input  logic [WIDTHx*SIZE-1:0]        b1_i,
  output logic [1:0]                    gnt_o,
  output logic [1:0]                    done_o,
  output logic                          err_o,
  output logic [WIDTH*SIZE*SIZE-1:0]    result_o,
  output logic                          mm_valid_o,
  output logic [WIDTHx*SIZE-1:0]        mm_a_o,
  output logic [WIDTHx*SIZE-1:0]        mm_b_o,
  input  logic                          mm_ready_i,
  input  logic [WIDTH*SIZE*SIZE-1:0]    mm_result_i
);

  localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(SIZE - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic                         owner_q, owner_d;
  logic [BW-1:0]                beat_q, beat_d;
  logic [TW-1:0]                tmo_q, tmo_d;
  logic                         err_q, err_d;
  logic [WIDTH*SIZE*SIZE-1:0]   result_q, result_d;
  logic                         pick;

`ifdef SYSTOLIC_RR_EN
  // rr_ptr_q names the client that wins when both request.
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    pick     = (req_i == 2'b11) ? rr_ptr_q : ~req_i[0];
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_IDLE && |req_i) rr_ptr_d = ~pick;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) rr_ptr_q <= 1'b0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb pick = ~req_i[0];
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      beat_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          owner_d = pick;
          beat_d  = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (beat_q == BEAT_LAST) begin
          beat_d  = '0;
          tmo_d   = '0;
          state_d = S_WAIT;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_WAIT: begin
        // A ready on the final timeout cycle still counts as success.
        if (mm_ready_i) begin
          result_d = mm_result_i;
          err_d    = 1'b0;
          state_d  = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o      = 2'b00;
    done_o     = 2'b00;
    err_o      = 1'b0;
    mm_valid_o = 1'b0;
    mm_a_o     = '0;
    mm_b_o     = '0;
    if (state_q == S_STREAM) begin
      gnt_o      = owner_q ? 2'b10 : 2'b01;
      mm_valid_o = (beat_q == '0);
      mm_a_o     = owner_q ? a1_i : a0_i;
      mm_b_o     = owner_q ? b1_i : b0_i;
    end
    if (state_q == S_DONE) begin
      done_o = owner_q ? 2'b10 : 2'b01;
      err_o  = err_q;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_systolic_mm_arbiter.sv
// Directed-plus-random bench for systolic_mm_arbiter with a matrix-level reference model and mock multiplier.
module tb_systolic_mm_arbiter;

  localparam int W  = 8;
  localparam int SZ = 2;
  localparam int WX = 8;
  localparam int TO = 8;

  logic              clock = 1'b0;
  logic              nreset;
  logic [1:0]        req_i;
  logic [WX*SZ-1:0]  a0_i, b0_i, a1_i, b1_i;
  logic [1:0]        gnt_o, done_o;
  logic              err_o;
  logic [W*SZ*SZ-1:0] result_o;
  logic              mm_valid_o;
  logic [WX*SZ-1:0]  mm_a_o, mm_b_o;
  logic              mm_ready_i;
  logic [W*SZ*SZ-1:0] mm_result_i;

  systolic_mm_arbiter #(.WIDTH(W), .SIZE(SZ), .WIDTHx(WX), .TIMEOUT(TO)) dut (
    .clock(clock), .nreset(nreset), .req_i(req_i),
    .a0_i(a0_i), .b0_i(b0_i), .a1_i(a1_i), .b1_i(b1_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
    .mm_valid_o(mm_valid_o), .mm_a_o(mm_a_o), .mm_b_o(mm_b_o),
    .mm_ready_i(mm_ready_i), .mm_result_i(mm_result_i)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference state: operand matrices per client, last captured product, round-robin priority.
  logic [7:0]  ma [2][SZ][SZ];
  logic [7:0]  mb [2][SZ][SZ];
  logic [31:0] model_res = '0;
  int          rr_prio = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [1:0] r);
`ifdef SYSTOLIC_RR_EN
    if (r == 2'b11) return rr_prio;
`endif
    return r[0] ? 0 : 1;
  endfunction

  function automatic logic [15:0] row_a(input int cl, input int s);
    return {ma[cl][s][1], ma[cl][s][0]};
  endfunction

  function automatic logic [15:0] row_b(input int cl, input int s);
    return {mb[cl][s][1], mb[cl][s][0]};
  endfunction

  function automatic logic [31:0] mat_prod(input int cl);
    logic [31:0] p;
    int sum;
    p = '0;
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++) begin
        sum = 0;
        for (int k = 0; k < SZ; k++) sum += int'(ma[cl][r][k]) * int'(mb[cl][k][c]);
        p[(r*SZ+c)*W +: W] = 8'(sum);
      end
    return p;
  endfunction

  task automatic rand_mats(input int cl);
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++) begin
        ma[cl][r][c] = 8'($urandom_range(0, 15));
        mb[cl][r][c] = 8'($urandom_range(0, 15));
      end
  endtask

  task automatic drive_beat(input int s);
    if (s < SZ) begin
      a0_i = row_a(0, s); b0_i = row_b(0, s);
      a1_i = row_a(1, s); b1_i = row_b(1, s);
    end else begin
      a0_i = '0; b0_i = '0; a1_i = '0; b1_i = '0;
    end
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge of the IDLE cycle after DONE.
  // rdy_wait: WAIT cycle index (0-based) carrying mm_ready_i, or outside 0..TO-1 for never.
  task automatic do_job(input logic [1:0] req, input logic [1:0] req_after,
                        input int rdy_wait, input bit drop);
    int own;
    bit timed_out;
    logic [31:0] prod;
    own = model_pick(req);
    rr_prio = 1 - own;
    prod = mat_prod(own);
    req_i = req;
    mm_ready_i = 1'b0;
    drive_beat(0);
    check("idle_gnt", 64'(gnt_o), 64'(0));
    for (int s = 0; s < SZ; s++) begin
      @(negedge clock);
      check("stream_gnt", 64'(gnt_o), 64'(2'b01 << own));
      check("stream_valid", 64'(mm_valid_o), 64'(s == 0));
      check("stream_a", 64'(mm_a_o), 64'(row_a(own, s)));
      check("stream_b", 64'(mm_b_o), 64'(row_b(own, s)));
      check("stream_done", 64'(done_o), 64'(0));
      if (drop && s == 1) req_i[own] = 1'b0;
      drive_beat(s + 1);
      mm_ready_i  = 1'($urandom_range(0, 1));
      mm_result_i = $urandom;
    end
    timed_out = 1'b0;
    for (int w = 0; w < TO; w++) begin
      @(negedge clock);
      check("wait_gnt", 64'(gnt_o), 64'(0));
      check("wait_valid", 64'(mm_valid_o), 64'(0));
      check("wait_a", 64'(mm_a_o), 64'(0));
      check("wait_done", 64'(done_o), 64'(0));
      check("wait_err", 64'(err_o), 64'(0));
      mm_ready_i  = (w == rdy_wait);
      mm_result_i = mm_ready_i ? prod : $urandom;
      if (mm_ready_i) begin
        model_res = prod;
        break;
      end
      if (w == TO - 1) timed_out = 1'b1;
    end
    @(negedge clock);
    check("done_pulse", 64'(done_o), 64'(2'b01 << own));
    check("done_err", 64'(err_o), 64'(timed_out));
    check("done_result", 64'(result_o), 64'(model_res));
    mm_ready_i = 1'b0;
    req_i = req_after;
    @(negedge clock);
    check("post_done", 64'(done_o), 64'(0));
    check("post_err", 64'(err_o), 64'(0));
    check("post_gnt", 64'(gnt_o), 64'(0));
    check("post_result", 64'(result_o), 64'(model_res));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 64'(gnt_o), 64'(0));
    check({tag, "_done"}, 64'(done_o), 64'(0));
    check({tag, "_err"}, 64'(err_o), 64'(0));
    check({tag, "_result"}, 64'(result_o), 64'(0));
    check({tag, "_valid"}, 64'(mm_valid_o), 64'(0));
    check({tag, "_a"}, 64'(mm_a_o), 64'(0));
    check({tag, "_b"}, 64'(mm_b_o), 64'(0));
  endtask

  initial begin
    nreset = 1'b0;
    req_i = 2'b00;
    mm_ready_i = 1'b0;
    mm_result_i = '0;
    a0_i = '0; b0_i = '0; a1_i = '0; b1_i = '0;
    #1;
    check_all_zero("reset");
    @(negedge clock);
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);

    // Contention straight after reset: fixed gives 0,0; round-robin gives 0,1.
    rand_mats(0); rand_mats(1);
    do_job(2'b11, 2'b11, 3, 1'b0);
    rand_mats(0); rand_mats(1);
    do_job(2'b11, 2'b00, 1, 1'b0);

    // Single job with known operands: ready 5 cycles after the valid beat.
    ma[0][0][0] = 8'd1; ma[0][0][1] = 8'd2; ma[0][1][0] = 8'd3; ma[0][1][1] = 8'd4;
    mb[0][0][0] = 8'd5; mb[0][0][1] = 8'd6; mb[0][1][0] = 8'd7; mb[0][1][1] = 8'd8;
    rand_mats(1);
    do_job(2'b01, 2'b00, 3, 1'b0);
    check("known_product", 64'(result_o), 64'({8'd50, 8'd43, 8'd22, 8'd19}));

    // Timeout, then ready on the last possible WAIT cycle.
    rand_mats(0); rand_mats(1);
    do_job(2'b01, 2'b00, -1, 1'b0);
    rand_mats(0); rand_mats(1);
    do_job(2'b01, 2'b00, TO - 1, 1'b0);

    // Client 1 drops its request in the second stream cycle.
    rand_mats(0); rand_mats(1);
    do_job(2'b10, 2'b00, 2, 1'b1);

    for (int i = 0; i < 8; i++) begin
      rand_mats(0); rand_mats(1);
      do_job(2'($urandom_range(1, 3)), 2'b00, $urandom_range(0, TO), 1'($urandom_range(0, 1)));
    end

    // Reset during WAIT abandons the job.
    rand_mats(0); rand_mats(1);
    req_i = 2'b01;
    drive_beat(0);
    for (int k = 0; k < SZ + 2; k++) begin
      @(negedge clock);
      mm_ready_i = 1'b0;
      drive_beat(k + 1);
    end
    nreset = 1'b0;
    model_res = '0;
    rr_prio = 0;
    #1;
    check_all_zero("midrst");
    req_i = 2'b00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("midrst_nodone", 64'(done_o), 64'(0));
    end
    nreset = 1'b1;
    @(negedge clock);
    check_all_zero("rst_release");
    rand_mats(0); rand_mats(1);
    do_job(2'b10, 2'b00, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
